// File: rtl/fir_mac_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fir_mac_seq_if                                                     |
// | Sample, coefficient-ROM and accumulator signals of fir_mac_seq.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface fir_mac_seq_if #(
    parameter int AW = 4
);
    logic [15:0]   in_sample;
    logic          in_vld;
    logic          in_rdy;
    logic [AW-1:0] coef_addr;
    logic [15:0]   coef;
    logic [17:0]   newSum;
    logic          accum_en;
    logic [17:0]   accum;
    logic [15:0]   out_sample;
    logic          out_vld;
    logic          out_rdy;

    modport slave (
        input  in_sample, in_vld, coef, accum, out_rdy,
        output in_rdy, coef_addr, newSum, accum_en, out_sample, out_vld
    );

    modport master (
        output in_sample, in_vld, coef, accum, out_rdy,
        input  in_rdy, coef_addr, newSum, accum_en, out_sample, out_vld
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fir_mac_seq                                                        |
// | FIR multiply-accumulate sequencer driving an external accumulator. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fir_mac_seq #(
    parameter int NTAPS = 16,
    parameter int AW    = 4
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    fir_mac_seq_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_MAC   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [AW-1:0] c_last_tap = AW'(NTAPS - 1);
    localparam logic [AW-1:0] c_one      = AW'(1);

    state_t             r_state;
    logic [15:0]        r_hist [NTAPS];
    logic [AW-1:0]      r_wp;
    logic [AW-1:0]      r_k;
    logic [AW-1:0]      r_coef_addr;
    logic signed [15:0] r_smp_q;
    logic               r_in_rdy;
    logic               r_out_vld;
    logic               r_accum_en;

    logic [AW-1:0]      w_rd_idx;
    logic signed [31:0] w_prod;
    logic [17:0]        w_tap;
    logic [17:0]        w_base;
    logic [17:0]        w_new_sum;
    logic               w_pos_ovf;
    logic               w_neg_ovf;
    logic [15:0]        w_sat;

    // Operand for the next tap: x[n-(k+1)], wrapping modulo NTAPS.
    assign w_rd_idx  = r_wp - r_k - c_one;
    assign w_prod    = 32'(r_smp_q) * 32'($signed(bus.coef));
    assign w_tap     = {w_prod[31], w_prod[31:15]};
    assign w_base    = (r_k == '0) ? '0 : bus.accum;
    assign w_new_sum = w_base + w_tap;

    assign w_pos_ovf = ~bus.accum[17] & (bus.accum[16:15] != 2'b00);
    assign w_neg_ovf =  bus.accum[17] & (bus.accum[16:15] != 2'b11);
    assign w_sat     = w_pos_ovf ? 16'h7FFF :
                       w_neg_ovf ? 16'h8000 : bus.accum[15:0];

    assign bus.in_rdy     = r_in_rdy;
    assign bus.out_vld    = r_out_vld;
    assign bus.accum_en   = r_accum_en;
    assign bus.coef_addr  = r_coef_addr;
    assign bus.newSum     = r_accum_en ? w_new_sum : '0;
    assign bus.out_sample = r_out_vld ? w_sat : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wp        <= '0;
            r_k         <= '0;
            r_coef_addr <= '0;
            r_smp_q     <= '0;
            r_in_rdy    <= 1'b1;
            r_out_vld   <= 1'b0;
            r_accum_en  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                r_hist[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_vld) begin
                        r_hist[r_wp] <= bus.in_sample;
                        r_coef_addr  <= '0;
                        r_k          <= '0;
                        r_in_rdy     <= 1'b0;
                        r_state      <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    r_smp_q     <= $signed(r_hist[r_wp]);
                    r_coef_addr <= c_one;
                    r_accum_en  <= 1'b1;
                    r_state     <= S_MAC;
                end
                S_MAC: begin
                    r_smp_q     <= $signed(r_hist[w_rd_idx]);
                    r_coef_addr <= r_coef_addr + c_one;
                    r_k         <= r_k + c_one;
                    if (r_k == c_last_tap) begin
                        r_wp       <= r_wp + c_one;
                        r_accum_en <= 1'b0;
                        r_out_vld  <= 1'b1;
                        r_state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_rdy) begin
                        r_out_vld <= 1'b0;
                        r_in_rdy  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fir_mac_seq                                                     |
// | Directed + random bench with ROM, accumulator and FIR model.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fir_mac_seq;
    localparam int NTAPS = 16;
    localparam int AW    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fir_mac_seq_if #(.AW(AW)) bus ();

    fir_mac_seq #(.NTAPS(NTAPS), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Coefficient ROM (one-cycle read) and 18-bit accumulator register.
    logic signed [15:0] rom [NTAPS];
    always @(posedge clk) bus.coef <= rom[bus.coef_addr];
    always @(posedge clk or negedge rst_n)
        if (!rst_n)            bus.accum <= '0;
        else if (bus.accum_en) bus.accum <= bus.newSum;

    int hist[$];            // newest sample first
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // y[n] = sat16( wrap18( sum_k floor(x[n-k]*c[k] / 2^15) ) )
    function automatic void model(output int acc, output int y);
        longint s;
        logic signed [17:0] w;
        s = 0;
        for (int k = 0; k < NTAPS; k++) begin
            longint x;
            x = (k < hist.size()) ? longint'(hist[k]) : 64'sd0;
            s += (x * longint'(rom[k])) >>> 15;
        end
        w   = s[17:0];
        acc = int'(w);
        y   = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : acc;
    endfunction

    function automatic void push_hist(input int x);
        hist.push_front(x);
        if (hist.size() > NTAPS) void'(hist.pop_back());
    endfunction

    task automatic wait_sig(input string tag, input bit which_out);
        int guard = 0;
        while (((which_out ? bus.out_vld : bus.in_rdy) !== 1'b1) && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        check(tag, which_out ? bus.out_vld : bus.in_rdy, 1);
    endtask

    task automatic run_sample(input logic signed [15:0] x, input int stall, output int obs_out);
        int acc, y;
        wait_sig("in_rdy before accept", 1'b0);
        bus.in_sample = x;
        bus.in_vld    = 1'b1;
        @(posedge clk); #1;
        bus.in_vld    = 1'b0;
        push_hist(int'(x));
        model(acc, y);
        wait_sig("out_vld timeout", 1'b1);
        repeat (stall) begin @(posedge clk); #1; end
        obs_out = int'($signed(bus.out_sample));
        check("out_sample vs model", $signed(bus.out_sample), y);
        check("accum vs model", $signed(bus.accum), acc);
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hist.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o, acc, y, held, first_vld;
        logic [31:0] en_mask;

        bus.in_sample = '0;
        bus.in_vld    = 1'b0;
        bus.out_rdy   = 1'b0;
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'(1024 * (k + 1));

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst in_rdy", bus.in_rdy, 1);
        check("rst out_vld", bus.out_vld, 0);
        check("rst accum_en", bus.accum_en, 0);
        check("rst newSum", bus.newSum, 0);
        check("rst coef_addr", bus.coef_addr, 0);
        check("rst out_sample", bus.out_sample, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse, first sample traced cycle by cycle
        bus.in_sample = 16'sd16384;
        bus.in_vld    = 1'b1;
        @(posedge clk); #1;
        bus.in_vld    = 1'b0;
        push_hist(16384);
        model(acc, y);
        en_mask   = '0;
        first_vld = -1;
        check("in_rdy low in PRIME", bus.in_rdy, 0);
        for (int c = 1; c <= NTAPS + 2; c++) begin
            if (c <= NTAPS) check($sformatf("coef_addr cycle %0d", c), bus.coef_addr, c - 1);
            en_mask[c] = bus.accum_en;
            if (bus.out_vld === 1'b1 && first_vld < 0) first_vld = c;
            if (c < NTAPS + 2) begin @(posedge clk); #1; end
        end
        check("accum_en cycle mask", en_mask, 32'h0003_FFFC);
        check("out_vld first cycle", first_vld, NTAPS + 2);
        check("impulse out 0", $signed(bus.out_sample), 512);
        check("impulse out 0 model", $signed(bus.out_sample), y);
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
        for (int i = 1; i < NTAPS; i++) begin
            run_sample(16'sd0, 0, o);
            check($sformatf("impulse out %0d", i), o, 512 * (i + 1));
        end

        // Saturation
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'sd8192;
        for (int i = 0; i < NTAPS; i++) run_sample(16'sd32767, 0, o);
        check("sat pos accum", $signed(bus.accum), 131056);
        check("sat pos out", o, 32767);
        for (int i = 0; i < NTAPS; i++) run_sample(-16'sd32768, 0, o);
        check("sat neg accum", $signed(bus.accum), -131072);
        check("sat neg out", o, -32768);

        // Back-pressure with ignored in_vld pulses
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'($urandom);
        wait_sig("bp in_rdy", 1'b0);
        bus.in_sample = 16'($urandom);
        bus.in_vld    = 1'b1;
        @(posedge clk); #1;
        bus.in_vld    = 1'b0;
        push_hist(int'($signed(bus.in_sample)));
        model(acc, y);
        wait_sig("bp out_vld", 1'b1);
        held = int'($signed(bus.out_sample));
        check("bp out_sample", held, y);
        for (int i = 0; i < 10; i++) begin
            bus.in_vld    = 1'($urandom_range(0, 1));
            bus.in_sample = 16'($urandom);
            @(posedge clk); #1;
            check("bp out_vld held", bus.out_vld, 1);
            check("bp out_sample held", $signed(bus.out_sample), held);
            check("bp in_rdy low", bus.in_rdy, 0);
        end
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        bus.out_rdy = 1'b0;
        check("bp idle after release", bus.in_rdy, 1);
        for (int i = 0; i < 3; i++) run_sample(16'($urandom), 0, o);

        // Pointer wrap: ramp through taps 0 and 15
        do_reset();
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'sd0;
        rom[0]  = 16'sd16384;
        rom[15] = 16'sd16384;
        for (int n = 1; n <= 40; n++) begin
            run_sample(16'(n), 0, o);
            if (n >= 16) check($sformatf("wrap out n=%0d", n), o, (n >>> 1) + ((n - 15) >>> 1));
        end

        // Random coefficients, samples and output stalls
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'($urandom);
        for (int i = 0; i < 24; i++) run_sample(16'($urandom), int'($urandom_range(0, 3)), o);

        // Reset in the middle of a MAC sweep
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'(1024 * (k + 1));
        wait_sig("mid-rst in_rdy", 1'b0);
        bus.in_sample = 16'($urandom);
        bus.in_vld    = 1'b1;
        @(posedge clk); #1;
        bus.in_vld    = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("mid-rst accum_en before", bus.accum_en, 1);
        rst_n = 1'b0;
        hist.delete();
        #1;
        check("mid-rst accum_en", bus.accum_en, 0);
        check("mid-rst newSum", bus.newSum, 0);
        check("mid-rst in_rdy", bus.in_rdy, 1);
        check("mid-rst out_vld", bus.out_vld, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mid-rst out_vld held low", bus.out_vld, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NTAPS; i++) begin
            run_sample((i == 0) ? 16'sd16384 : 16'sd0, 0, o);
            check($sformatf("post-rst impulse %0d", i), o, 512 * (i + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fir_mac_seq.md
# fir_mac_seq

FIR multiply-accumulate sequencer for the audio datapath. It accepts one 16-bit signed sample per handshake and stores it in an internal circular history buffer. It then steps through `NTAPS` coefficient/sample products, driving the `newSum`/`en` inputs of the downstream 18-bit accumulator register and reading its `accum` output back. When the sweep completes, it presents the saturated 16-bit filter output.

## Interface
Parameters:
- `NTAPS`, default 16: number of filter taps; power of 2, range 2..64.
- `AW`, default 4: address width, equal to log2(`NTAPS`).

Ports:
- `clk`  input  1: system clock; all state updates on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_sample`  input  16: signed input audio sample.
- `in_vld`  input  1: `in_sample` is valid.
- `in_rdy`  output  1: block can accept a sample; high only in IDLE.
- `coef_addr`  output  AW: registered address to the external coefficient ROM.
- `coef`  input  16: signed Q1.15 coefficient; valid the cycle after `coef_addr` is registered (1-cycle synchronous ROM).
- `newSum`  output  18: next accumulator value, to the accumulator `newSum` input.
- `accum_en`  output  1: accumulator load enable, to the accumulator `en` input.
- `accum`  input  18: current accumulator value, read back from the accumulator.
- `out_sample`  output  16: filter result, saturated.
- `out_vld`  output  1: `out_sample` is valid; held until accepted.
- `out_rdy`  input  1: downstream accepts `out_sample`.

## Operation
- History buffer `buf[0..NTAPS-1]` holds 16-bit entries; write pointer `wp` is AW bits. Both reset to 0.
- Tap k uses x[n-k], read from `buf[(wp - k) mod NTAPS]`. Index arithmetic wraps modulo `NTAPS`.
- State machine, reset state IDLE:
  - IDLE: `in_rdy`=1.
    - On `in_vld`: write `buf[wp] <= in_sample`, set `coef_addr <= 0`, set tap counter `k <= 0`, then go to PRIME.
    - `in_vld` while not in IDLE is ignored; no sample is written.
  - PRIME: the ROM is reading coefficient 0.
    - Register operand `smp_q <= buf[wp]`.
    - Set `coef_addr <= 1`.
    - Go to MAC.
  - MAC, one tap per cycle:
    - `p = smp_q * coef`, a 32-bit signed product.
    - `t` = p arithmetically shifted right by 15 (`p >>> 15`), sign-extended to 18 bits.
    - `newSum = (k==0 ? 18'd0 : accum) + t`, wrapping in 18 bits with no saturation inside the accumulator.
    - `accum_en` = 1.
    - Each cycle: `smp_q <= buf[(wp-k-1) mod NTAPS]`, `coef_addr <= coef_addr+1` (wraps), `k <= k+1`.
    - When `k == NTAPS-1`: `wp <= wp+1` (wraps) and go to OUT.
  - OUT:
    - `out_vld` = 1.
    - `out_sample = sat16(accum)`: values above 32767 become 32767; values below -32768 become -32768; otherwise `accum[15:0]`.
    - On `out_rdy`: go to IDLE.
- Outside MAC: `accum_en` = 0 and `newSum` = 0.
- Reset values:
  - State = IDLE.
  - `in_rdy` = 1 once reset is asserted.
  - `out_vld` = 0, `accum_en` = 0, `newSum` = 0, `coef_addr` = 0, `out_sample` = 0.
  - `buf` = all 0, `wp` = 0, `k` = 0.
- Reset mid-operation (any state): all of the above return to reset values immediately. The partial sweep is discarded, the buffer history is cleared, and no `out_vld` is produced.

## Timing
- Cycle 0: `in_vld && in_rdy` (accept).
- Cycle 1: PRIME.
- Cycles 2..NTAPS+1: MAC; `accum_en` high for exactly `NTAPS` consecutive cycles.
- Cycle NTAPS+2: OUT; `out_vld` rises and `accum` holds the final sum.
- Minimum sample period is NTAPS+3 cycles: OUT, then IDLE, then accept. `out_rdy` may be high in the first OUT cycle.
- Back-pressure: `out_vld` and `out_sample` are held stable while `out_rdy` is low, and `in_rdy` stays 0 during that time.
- `out_sample` depends combinationally on `accum`. `accum` is stable in OUT because `accum_en` = 0.

## Test plan
- Impulse response. Setup: `NTAPS`=16, `coef[k]=1024*(k+1)`. Stimulus: one sample of 16384, then 15 zeros. Required: outputs 512, 1024, 1536, … 8192, in order.
- Positive saturation. Setup: all `coef` = 8192. Stimulus: 16 samples of 32767. Required: the 16th result has `accum` = 131056 and `out_sample` = 32767, with no wrap. Stimulus: 16 samples of -32768. Required: `accum` = -131072 and `out_sample` = -32768.
- Handshake and back-pressure:
  - Hold `out_rdy`=0 for 10 cycles. Required: `out_vld` and `out_sample` stay stable, `in_rdy` stays 0, and `in_vld` pulses during this time are ignored with the buffer unchanged.
  - Release `out_rdy`. Required: IDLE the next cycle.
- Cycle count: accept at cycle 0. Required: `accum_en` is high in cycles 2..17, `out_vld` rises at cycle 18, and the `coef_addr` sequence is 0..15.
- Pointer wrap: stream 40 samples forming a ramp 1..40 with coef = 16384 only at taps 0 and 15. Required: from output 16 onward, each output equals (x[n] + x[n-15]) >>> 1 per the per-tap truncation rule, confirming `wp` and read-index wrap.
- Reset mid-MAC: assert `rst_n`=0 at MAC cycle 5. Required: `accum_en` = 0 and state = IDLE immediately, with no `out_vld`. The next impulse reproduces the clean impulse response, confirming history was cleared.
